hazard_ctrl: RTL

//  Pipeline sequencer for the in-order core. It owns the stall_*/flush_* controls of the F/D/E/M stages,

---
 rtl/hazard_ctrl_pkg.sv | 27 ++
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl_reg_scoreboard.sv | 62 ++++++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared core types: register index, machine word, NOP encoding, major opcodes and the
// hazard-controller FSM state.
package hazard_ctrl_pkg;

  typedef logic [31:0] word_t;

  localparam word_t NOP = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;

  localparam int NREG_DEF  = 32;
  localparam int REG_W_DEF = $clog2(NREG_DEF);

  typedef logic [REG_W_DEF-1:0] reg_idx_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage status in, stall/flush controls out.
// master = pipeline stages driving status, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 32
);
  logic              d_valid;
  logic [REG_W-1:0]  d_rs1;
  logic [REG_W-1:0]  d_rs2;
  logic              d_use1;
  logic              d_use2;
  logic [REG_W-1:0]  d_rd;
  logic              d_wen;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic              m_mem_req;
  logic              m_mem_ack;
  logic              e_redirect;
  logic              stall_f;
  logic              stall_d;
  logic              stall_e;
  logic              stall_m;
  logic              flush_f;
  logic              flush_d;
  logic [PERF_W-1:0] stall_cycles;
  logic              mem_err;

  modport master (
    output d_valid, d_rs1, d_rs2, d_use1, d_use2, d_rd, d_wen,
    output wb_valid, wb_rd, m_mem_req, m_mem_ack, e_redirect,
    input  stall_f, stall_d, stall_e, stall_m, flush_f, flush_d,
    input  stall_cycles, mem_err
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_use1, d_use2, d_rd, d_wen,
    input  wb_valid, wb_rd, m_mem_req, m_mem_ack, e_redirect,
    output stall_f, stall_d, stall_e, stall_m, flush_f, flush_d,
    output stall_cycles, mem_err
  );

endinterface

// File: rtl/hazard_ctrl_reg_scoreboard.sv
// Per-register count of in-flight writes; pend lookups are combinational and see a
// same-cycle writeback as already retired (regfile writes before it reads).
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int REG_W = 5,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             wb,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic             pend1,
  output logic             pend2
);

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  inc;
  logic [NREG-1:0]  dec;
  logic [CNT_W-1:0] eff1;
  logic [CNT_W-1:0] eff2;

  // x0 is never tracked: its inc/dec stay low so cnt[0] holds zero forever
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NREG; r++) begin
      inc[r] = (r != 0) && issue && (issue_rd == REG_W'(r));
      dec[r] = (r != 0) && wb    && (wb_rd    == REG_W'(r));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc[r] && !dec[r])      cnt[r] <= cnt[r] + 1'b1;
        else if (dec[r] && !inc[r]) cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_comb begin
    eff1  = cnt[rs1] - CNT_W'(wb && (wb_rd == rs1));
    eff2  = cnt[rs2] - CNT_W'(wb && (wb_rd == rs2));
    pend1 = (rs1 != '0) && (eff1 != '0);
    pend2 = (rs2 != '0) && (eff2 != '0);
  end

  // Counter wrap means the pipe depth outgrew CNT_W or a writeback had no matching issue
  for (genvar g = 1; g < NREG; g++) begin : g_chk
    a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
      (inc[g] && !dec[g]) |-> (cnt[g] != {CNT_W{1'b1}}));
    a_no_udf: assert property (@(posedge clk) disable iff (!rst_n)
      (dec[g] && !inc[g]) |-> (cnt[g] != '0));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: zero-latency stall/flush priority (mem freeze > redirect > RAW hazard),
// write scoreboard, memory-wait FSM with sticky timeout, and a stall-cycle perf counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NREG        = 32,
  parameter int REG_W       = 5,
  parameter int CNT_W       = 2,
  parameter int PERF_W      = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  localparam int WT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t         state;
  hz_state_t         state_nxt;
  logic [WT_W-1:0]   wait_cnt;
  logic              mem_err_q;
  logic [PERF_W-1:0] stall_cycles_q;

  logic freeze;
  logic hazard;
  logic pend1;
  logic pend2;
  logic issue;
  logic wait_enter;
  logic timeout;
  logic stall_f, stall_d, stall_e, stall_m, flush_f, flush_d;

  assign freeze = bus.m_mem_req & ~bus.m_mem_ack;
  assign hazard = bus.d_valid & ((bus.d_use1 & pend1) | (bus.d_use2 & pend2));
  assign issue  = bus.d_valid & bus.d_wen & (bus.d_rd != '0) & ~stall_d & ~flush_d;

  reg_scoreboard #(
    .NREG  (NREG),
    .REG_W (REG_W),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (issue),
    .issue_rd (bus.d_rd),
    .wb       (bus.wb_valid),
    .wb_rd    (bus.wb_rd),
    .rs1      (bus.d_rs1),
    .rs2      (bus.d_rs2),
    .pend1    (pend1),
    .pend2    (pend2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (freeze) state_nxt = MEM_WAIT;
      MEM_WAIT: if (bus.m_mem_ack || !bus.m_mem_req) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Controls are gated by rst_n so the pipe is released the instant reset asserts.
  // A held E stage keeps e_redirect alive, so ignoring it under freeze loses nothing.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_f = 1'b0;
    flush_d = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end else if (bus.e_redirect) begin
        flush_f = 1'b1;
        flush_d = 1'b1;
      end else if (hazard) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_d = 1'b1;
      end
    end
  end

  assign wait_enter = (state == RUN) && (state_nxt == MEM_WAIT);
  assign timeout    = (state == MEM_WAIT) && (wait_cnt == WT_W'(MEM_TIMEOUT));

  // wait_cnt saturates at MEM_TIMEOUT; the sticky flag carries the event onward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (wait_enter)
        wait_cnt <= '0;
      else if ((state == MEM_WAIT) && (wait_cnt != WT_W'(MEM_TIMEOUT)))
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout) mem_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       stall_cycles_q <= '0;
    else if (stall_d) stall_cycles_q <= stall_cycles_q + PERF_W'(1);
  end

  assign bus.stall_f      = stall_f;
  assign bus.stall_d      = stall_d;
  assign bus.stall_e      = stall_e;
  assign bus.stall_m      = stall_m;
  assign bus.flush_f      = flush_f;
  assign bus.flush_d      = flush_d;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.mem_err      = mem_err_q | timeout;

endmodule
